// File: rtl/instr_imm_encoder.sv
// Immediate encoder and instruction-RAM loader: packs imm_in into base_word per imm_src and streams the result to RAM.
// Optional build macro IMM_LOOPBACK_CHECK_EN adds a registered decode-back check with a loopback_mismatch port.
module instr_imm_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       base_word,
  input  logic [7:0]        imm_in,
  input  logic [1:0]        imm_src,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              imm_err,
  output logic [7:0]        err_count,
  output logic [ADDR_W:0]   words_written,
`ifdef IMM_LOOPBACK_CHECK_EN
  output logic              loopback_mismatch,
`endif
  output logic              load_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   acc_cnt_q, acc_cnt_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic              imm_err_q;

  logic              accept;
  logic              session_clear;
  logic [15:0]       enc_word;
  logic              enc_err;

  assign in_ready      = (state_q == S_LOAD) && (acc_cnt_q < DEPTH_C);
  assign accept        = in_valid & in_ready;
  assign load_done     = (state_q == S_FULL);
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign imm_err       = imm_err_q;
  assign err_count     = err_cnt_q;
  assign words_written = words_q;

  // Field packing; out-of-range values are still written, truncated to the field width.
  always_comb begin
    enc_word = base_word;
    enc_err  = 1'b0;
    case (imm_src)
      2'b00: begin
        enc_word = {base_word[15:9], imm_in[7:0], base_word[0]};
      end
      2'b01: begin
        enc_word = {base_word[15:6], imm_in[5:0]};
        enc_err  = !((imm_in[7:5] == 3'b000) || (imm_in[7:5] == 3'b111));
      end
      2'b10: begin
        enc_word = {base_word[15:6], imm_in[4:0], base_word[0]};
        enc_err  = (imm_in[7:5] != 3'b000);
      end
      default: begin
        enc_word = base_word;
        enc_err  = 1'b1;
      end
    endcase
  end

  // load_stop takes priority over load_start in every state.
  always_comb begin
    state_d       = state_q;
    session_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start && !load_stop) begin
          state_d       = S_LOAD;
          session_clear = 1'b1;
        end
      end
      S_LOAD: begin
        if (load_stop) begin
          state_d = S_IDLE;
        end else if (mem_we_q && (mem_addr_q == LAST_ADDR)) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (load_stop) begin
          state_d = S_IDLE;
        end else if (load_start) begin
          state_d       = S_LOAD;
          session_clear = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    words_d   = words_q;
    err_cnt_d = err_cnt_q;
    if (session_clear) begin
      acc_cnt_d = '0;
      words_d   = '0;
      err_cnt_d = '0;
    end else begin
      if (accept) begin
        acc_cnt_d = acc_cnt_q + (ADDR_W + 1)'(1);
      end
      if (mem_we_q) begin
        words_d = words_q + (ADDR_W + 1)'(1);
        if (imm_err_q && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_cnt_q   <= '0;
      words_q     <= '0;
      err_cnt_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      imm_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      words_q   <= words_d;
      err_cnt_q <= err_cnt_d;
      mem_we_q  <= accept;
      imm_err_q <= accept & enc_err;
      if (accept) begin
        mem_addr_q  <= acc_cnt_q[ADDR_W-1:0];
        mem_wdata_q <= enc_word;
      end
    end
  end

`ifdef IMM_LOOPBACK_CHECK_EN
  logic [7:0] imm_cap_q;
  logic [1:0] src_cap_q;
  logic [7:0] dec_imm;
  logic       lb_mismatch_q;

  // Decode-side extraction rules applied to the word just written.
  always_comb begin
    dec_imm = 8'h00;
    case (src_cap_q)
      2'b00:   dec_imm = mem_wdata_q[8:1];
      2'b01:   dec_imm = {{2{mem_wdata_q[5]}}, mem_wdata_q[5:0]};
      2'b10:   dec_imm = {3'b000, mem_wdata_q[5:1]};
      default: dec_imm = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_cap_q     <= '0;
      src_cap_q     <= '0;
      lb_mismatch_q <= 1'b0;
    end else begin
      if (accept) begin
        imm_cap_q <= imm_in;
        src_cap_q <= imm_src;
      end
      lb_mismatch_q <= mem_we_q && !imm_err_q && (dec_imm != imm_cap_q);
    end
  end

  assign loopback_mismatch = lb_mismatch_q;
`endif

endmodule
